// File: rtl/sample_capture_buffer_pkg.sv
// Shared definitions for the sample capture buffer: default widths, the
// auto-trigger timeout and the acquisition state encoding.
package sample_capture_buffer_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1024;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        CAPTURE = ST_CAPTURE,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/sample_capture_buffer_if.sv
// Sample stream, control, readout and status signals of the capture buffer.
// master drives samples/control/read address; slave is the capture buffer.
interface sample_capture_buffer_if
    import sample_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              arm;
    logic              auto_en;
    logic [DATA_W-1:0] trig_level;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              auto_trig;

    modport master (
        output sample_in, sample_valid, arm, auto_en, trig_level, rd_addr,
        input  rd_data, busy, done, auto_trig
    );

    modport slave (
        input  sample_in, sample_valid, arm, auto_en, trig_level, rd_addr,
        output rd_data, busy, done, auto_trig
    );

endinterface

// File: rtl/sample_capture_buffer_ram.sv
// Simple dual-port frame RAM: one synchronous write port, one registered
// read-first read port. Contents are never cleared; only the read output
// register is reset.
module sample_ram
    import sample_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Registered read; a same-cycle write to ra is seen on the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
        end else begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// Threshold-triggered frame capture: waits in ARMED for a rising crossing of
// trig_level (or a timeout when auto_en is set), then stores 2^ADDR_W
// consecutive samples, starting with the trigger sample, and holds them.
module sample_capture_buffer
    import sample_capture_buffer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    sample_capture_buffer_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0]  tmo_cnt_reg;
    logic [DATA_W-1:0] prev_sample_reg;
    logic              prev_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              auto_trig_reg;

    logic              crossing;
    logic              force_trig;
    logic              trigger;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;

    // Trigger decision and RAM write control for the current strobe.
    always_comb begin
        crossing   = prev_valid_reg
                     && (prev_sample_reg < bus.trig_level)
                     && (bus.sample_in >= bus.trig_level);
        force_trig = bus.auto_en && (tmo_cnt_reg == TMO_LAST) && !crossing;
        trigger    = (state_reg == ARMED) && bus.sample_valid
                     && (crossing || force_trig);
        ram_we     = trigger || ((state_reg == CAPTURE) && bus.sample_valid);
        ram_wa     = (state_reg == CAPTURE) ? wr_ptr_reg : '0;
    end

    // Acquisition FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            tmo_cnt_reg     <= '0;
            prev_sample_reg <= '0;
            prev_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            auto_trig_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // A strobe coincident with arm is deliberately dropped.
                    if (bus.arm) begin
                        state_reg      <= ARMED;
                        wr_ptr_reg     <= '0;
                        tmo_cnt_reg    <= '0;
                        prev_valid_reg <= 1'b0;
                        auto_trig_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                    end
                end
                ARMED: begin
                    if (bus.sample_valid) begin
                        if (crossing || force_trig) begin
                            state_reg     <= CAPTURE;
                            wr_ptr_reg    <= ADDR_W'(1);
                            auto_trig_reg <= force_trig;
                        end else begin
                            prev_sample_reg <= bus.sample_in;
                            prev_valid_reg  <= 1'b1;
                            // Saturates so auto_en=0 waits forever without wrap.
                            if (tmo_cnt_reg != TMO_LAST) begin
                                tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.sample_valid) begin
                        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                        if (wr_ptr_reg == LAST_ADDR) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.auto_trig = auto_trig_reg;

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (bus.sample_in),
        .ra  (bus.rd_addr),
        .rd  (bus.rd_data)
    );

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Self-checking bench for sample_capture_buffer. A stream-level model picks
// the trigger strobe from the sample list and derives the expected frame
// and done/busy timing.
module tb_sample_capture_buffer;
    import sample_capture_buffer_pkg::*;

    localparam int TIMEOUT = 1024;
    localparam int FRAME   = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sample_capture_buffer_if bus ();

    sample_capture_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] stream [$];
    bit         obs_done [$];
    bit         obs_busy [$];
    logic [7:0] rd_frame [FRAME];
    logic [7:0] exp_mem  [FRAME];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic build_ramp(input int start, input int step, input int len);
        stream.delete();
        for (int k = 0; k < len; k++) stream.push_back(8'(start + step * k));
    endtask

    // First strobe that is a rising crossing, else the TIMEOUT-th strobe.
    task automatic model_trigger(input logic [7:0] lvl, input bit aen,
                                 output int idx, output bit by_timeout);
        idx = -1;
        by_timeout = 1'b0;
        for (int i = 0; i < stream.size(); i++) begin
            if (i > 0 && stream[i-1] < lvl && stream[i] >= lvl) begin
                idx = i;
                return;
            end
            if (aen && i == TIMEOUT - 1) begin
                idx = i;
                by_timeout = 1'b1;
                return;
            end
        end
    endtask

    task automatic commit_frame(input int idx);
        for (int k = 0; k < FRAME; k++) exp_mem[k] = stream[idx + k];
    endtask

    task automatic drive_stream(input int gap_pct, input int arm_at);
        obs_done.delete();
        obs_busy.delete();
        for (int i = 0; i < stream.size(); i++) begin
            if (gap_pct > 0) begin
                while (int'($urandom_range(99)) < gap_pct) tick();
            end
            bus.sample_in    = stream[i];
            bus.sample_valid = 1'b1;
            bus.arm          = (i == arm_at);
            tick();
            bus.sample_valid = 1'b0;
            bus.arm          = 1'b0;
            obs_done.push_back(bus.done);
            obs_busy.push_back(bus.busy);
        end
    endtask

    task automatic read_frame();
        for (int a = 0; a < FRAME; a++) begin
            bus.rd_addr = 8'(a);
            tick();
            rd_frame[a] = bus.rd_data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sample_in = '0; bus.sample_valid = 1'b0; bus.arm = 1'b0;
        bus.auto_en = 1'b0; bus.trig_level = '0; bus.rd_addr = '0;
        repeat (3) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_checks++; if (bus.auto_trig !== 1'b0) begin n_fail++; $display("FAIL reset_auto_trig got=%b exp=0", bus.auto_trig); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
        rst = 1'b0;
        repeat (2) tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", bus.busy, bus.done); end
        $display("test_reset done");
    endtask

    task automatic test_ramp_trigger();
        int idx; bit by_to;
        bus.trig_level = 8'h80; bus.auto_en = 1'b0;
        build_ramp(8'h70, 8, 300);
        model_trigger(8'h80, 1'b0, idx, by_to);
        commit_frame(idx);
        do_arm();
        n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL ramp_arm busy=%b done=%b exp=1/0", bus.busy, bus.done); end
        drive_stream(0, -1);
        for (int i = 0; i < stream.size(); i++) begin
            bit exp_d = (i >= idx + FRAME - 1);
            n_checks++; if (obs_done[i] !== exp_d || obs_busy[i] !== !exp_d) begin n_fail++; $display("FAIL ramp_status strobe=%0d done=%b busy=%b exp done=%b", i, obs_done[i], obs_busy[i], exp_d); end
        end
        n_checks++; if (bus.auto_trig !== 1'b0) begin n_fail++; $display("FAIL ramp_auto_trig got=%b exp=0", bus.auto_trig); end
        read_frame();
        n_checks++; if (rd_frame[0] !== 8'h80) begin n_fail++; $display("FAIL ramp_word0 got=%h exp=80", rd_frame[0]); end
        n_checks++; if (rd_frame[1] !== 8'h88) begin n_fail++; $display("FAIL ramp_word1 got=%h exp=88", rd_frame[1]); end
        for (int a = 0; a < FRAME; a++) begin
            n_checks++; if (rd_frame[a] !== exp_mem[a]) begin n_fail++; $display("FAIL ramp_frame addr=%0d got=%h exp=%h", a, rd_frame[a], exp_mem[a]); end
        end
        $display("test_ramp_trigger done: trigger strobe %0d", idx);
    endtask

    task automatic test_arm_coincident();
        int idx; bit by_to;
        bus.trig_level = 8'h80; bus.auto_en = 1'b0;
        bus.arm = 1'b1; bus.sample_valid = 1'b1; bus.sample_in = 8'h85;
        tick();
        bus.arm = 1'b0; bus.sample_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL coinc_arm busy=%b done=%b exp=1/0", bus.busy, bus.done); end
        stream.delete();
        stream.push_back(8'h90); stream.push_back(8'h10); stream.push_back(8'hA0);
        for (int k = 0; k < 300; k++) stream.push_back(8'($urandom));
        model_trigger(8'h80, 1'b0, idx, by_to);
        commit_frame(idx);
        drive_stream(20, -1);
        for (int i = 0; i < stream.size(); i++) begin
            bit exp_d = (i >= idx + FRAME - 1);
            n_checks++; if (obs_done[i] !== exp_d || obs_busy[i] !== !exp_d) begin n_fail++; $display("FAIL coinc_status strobe=%0d done=%b busy=%b exp done=%b", i, obs_done[i], obs_busy[i], exp_d); end
        end
        read_frame();
        n_checks++; if (rd_frame[0] !== 8'hA0) begin n_fail++; $display("FAIL coinc_word0 got=%h exp=a0", rd_frame[0]); end
        for (int a = 0; a < FRAME; a++) begin
            n_checks++; if (rd_frame[a] !== exp_mem[a]) begin n_fail++; $display("FAIL coinc_frame addr=%0d got=%h exp=%h", a, rd_frame[a], exp_mem[a]); end
        end
        $display("test_arm_coincident done: trigger strobe %0d", idx);
    endtask

    task automatic test_random_frames(input int n);
        for (int it = 0; it < n; it++) begin
            int idx; bit by_to; int arm_at;
            logic [7:0] lvl;
            lvl = 8'($urandom_range(32, 224));
            bus.trig_level = lvl; bus.auto_en = 1'b1;
            stream.delete();
            for (int k = 0; k < TIMEOUT + FRAME + 20; k++) stream.push_back(8'($urandom));
            model_trigger(lvl, 1'b1, idx, by_to);
            commit_frame(idx);
            arm_at = idx + int'($urandom_range(1, 200));
            do_arm();
            n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.auto_trig !== 1'b0) begin n_fail++; $display("FAIL rand_arm it=%0d busy=%b done=%b auto=%b exp=1/0/0", it, bus.busy, bus.done, bus.auto_trig); end
            drive_stream(30, arm_at);
            for (int i = 0; i < stream.size(); i++) begin
                bit exp_d = (i >= idx + FRAME - 1);
                n_checks++; if (obs_done[i] !== exp_d || obs_busy[i] !== !exp_d) begin n_fail++; $display("FAIL rand_status it=%0d strobe=%0d done=%b busy=%b exp done=%b", it, i, obs_done[i], obs_busy[i], exp_d); end
            end
            n_checks++; if (bus.auto_trig !== by_to) begin n_fail++; $display("FAIL rand_auto_trig it=%0d got=%b exp=%b", it, bus.auto_trig, by_to); end
            read_frame();
            for (int a = 0; a < FRAME; a++) begin
                n_checks++; if (rd_frame[a] !== exp_mem[a]) begin n_fail++; $display("FAIL rand_frame it=%0d addr=%0d got=%h exp=%h", it, a, rd_frame[a], exp_mem[a]); end
            end
            $display("test_random_frames it=%0d lvl=%h trigger strobe %0d arm pulse at %0d", it, lvl, idx, arm_at);
        end
    endtask

    task automatic test_reset_mid_capture();
        int idx; bit by_to;
        bus.trig_level = 8'h80; bus.auto_en = 1'b0;
        build_ramp(8'h70, 8, 102);
        model_trigger(8'h80, 1'b0, idx, by_to);
        do_arm();
        drive_stream(0, -1);
        n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_before_reset busy=%b done=%b exp=1/0", bus.busy, bus.done); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset busy=%b done=%b exp=0/0", bus.busy, bus.done); end
        rst = 1'b0;
        tick();
        build_ramp(8'h05, 3, 400);
        model_trigger(8'h80, 1'b0, idx, by_to);
        commit_frame(idx);
        do_arm();
        drive_stream(10, -1);
        for (int i = 0; i < stream.size(); i++) begin
            bit exp_d = (i >= idx + FRAME - 1);
            n_checks++; if (obs_done[i] !== exp_d || obs_busy[i] !== !exp_d) begin n_fail++; $display("FAIL mid_status strobe=%0d done=%b busy=%b exp done=%b", i, obs_done[i], obs_busy[i], exp_d); end
        end
        read_frame();
        for (int a = 0; a < FRAME; a++) begin
            n_checks++; if (rd_frame[a] !== exp_mem[a]) begin n_fail++; $display("FAIL mid_frame addr=%0d got=%h exp=%h", a, rd_frame[a], exp_mem[a]); end
        end
        $display("test_reset_mid_capture done: rearmed trigger strobe %0d", idx);
    endtask

    task automatic test_no_crossing();
        bus.trig_level = 8'h80; bus.auto_en = 1'b0;
        stream.delete();
        for (int k = 0; k < 1500; k++) stream.push_back(8'h90);
        do_arm();
        drive_stream(0, -1);
        for (int i = 0; i < stream.size(); i++) begin
            n_checks++; if (obs_busy[i] !== 1'b1 || obs_done[i] !== 1'b0) begin n_fail++; $display("FAIL nocross_status strobe=%0d busy=%b done=%b exp=1/0", i, obs_busy[i], obs_done[i]); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL nocross_reset busy=%b exp=0", bus.busy); end
        $display("test_no_crossing done: %0d strobes without trigger", stream.size());
    endtask

    task automatic test_auto_trigger();
        int idx; bit by_to;
        bus.trig_level = 8'h80; bus.auto_en = 1'b1;
        stream.delete();
        for (int k = 0; k < TIMEOUT + FRAME + 8; k++) stream.push_back(8'h10);
        model_trigger(8'h80, 1'b1, idx, by_to);
        commit_frame(idx);
        do_arm();
        drive_stream(0, -1);
        for (int i = 0; i < stream.size(); i++) begin
            bit exp_d = (i >= idx + FRAME - 1);
            n_checks++; if (obs_done[i] !== exp_d || obs_busy[i] !== !exp_d) begin n_fail++; $display("FAIL auto_status strobe=%0d done=%b busy=%b exp done=%b", i, obs_done[i], obs_busy[i], exp_d); end
        end
        n_checks++; if (bus.auto_trig !== 1'b1) begin n_fail++; $display("FAIL auto_trig_flag got=%b exp=1", bus.auto_trig); end
        read_frame();
        for (int a = 0; a < FRAME; a++) begin
            n_checks++; if (rd_frame[a] !== 8'h10) begin n_fail++; $display("FAIL auto_frame addr=%0d got=%h exp=10", a, rd_frame[a]); end
        end
        $display("test_auto_trigger done: forced on strobe %0d", idx + 1);
    endtask

    initial begin
        test_reset();
        test_ramp_trigger();
        test_arm_coincident();
        test_random_frames(3);
        test_reset_mid_capture();
        test_no_crossing();
        test_auto_trigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_capture_buffer.md
# sample_capture_buffer

Downstream consumer of the SPI ADC controller's 8-bit sample output. It watches the sample stream for a rising-edge threshold crossing, with an auto-trigger timeout. After a trigger it records a fixed-length frame of consecutive samples into an internal dual-port RAM. It then holds the frame stable for the display/readout logic to read through an independent synchronous read port.

## Interface
- DATA_W, 8: sample width; matches the SPI controller buffer output.
- ADDR_W, 8: frame address width; frame depth = 2^ADDR_W = 256 samples.
- TIMEOUT, 1024: sample strobes spent in ARMED before an auto-trigger is forced.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  DATA_W  sample from the SPI controller buffer register.
- sample_valid  in  1  one-cycle strobe: sample_in holds a new sample this cycle.
- arm  in  1  one-cycle pulse: start a new acquisition.
- auto_en  in  1  1 = timeout auto-trigger enabled; 0 = wait indefinitely.
- trig_level  in  DATA_W  unsigned trigger threshold.
- rd_addr  in  ADDR_W  readout address.
- rd_data  out  DATA_W  RAM word at rd_addr; registered.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE; frame complete and stable.
- auto_trig  out  1  the last frame was started by timeout, not by a level crossing.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset enters IDLE.
- IDLE, arm=1 → ARMED:
  - clear prev_valid, the timeout counter and auto_trig.
  - A sample_valid in the same cycle is ignored.
- ARMED, sample_valid=1:
  - Crossing when prev_valid=1, prev_sample < trig_level and sample_in >= trig_level (unsigned).
  - On a crossing: write sample_in to address 0, wr_ptr←1, → CAPTURE.
  - Otherwise: prev_sample←sample_in, prev_valid←1, timeout counter +1.
  - Counter reaches TIMEOUT-1 with auto_en=1 and no crossing: treat the strobe as a trigger (write address 0, → CAPTURE) and set auto_trig=1.
  - auto_en=0: counter saturates, no forced trigger.
- CAPTURE, sample_valid=1: write sample_in at wr_ptr, wr_ptr+1. The write at address 2^ADDR_W-1 → DONE. wr_ptr never wraps within a frame.
- DONE: no writes. arm=1 → ARMED, same clears as from IDLE.
- arm in ARMED or CAPTURE is ignored; an acquisition in progress is never restarted.
- The read port is independent of state. Reads during CAPTURE return a partially updated frame; readers use done.
- RAM contents are not cleared by reset or arm.

## Timing
- Reset values: rd_data=0 (output register), busy=0, done=0, auto_trig=0, state IDLE, wr_ptr=0, counter=0, prev_valid=0.
- State and status outputs are registered. busy rises the cycle after arm is sampled.
- The trigger sample is written in its sample_valid cycle; the next sample_valid writes address 1.
- done rises the cycle after the write to address 255; busy falls in that same cycle.
- Frame = exactly 256 consecutive sample_valid strobes, counting the trigger sample.
- rd_data latency: 1 cycle from rd_addr.
- Same-address read and write in one cycle: read returns the old data (read-first).
- Reset mid-CAPTURE → IDLE immediately, done=0, frame partial.

## Structure
- Shared package: state encoding (IDLE/ARMED/CAPTURE/DONE as 2-bit localparams), DATA_W and ADDR_W defaults.
- One sub-module, sample_ram: simple dual-port, 2^ADDR_W × DATA_W, one synchronous write port, one registered read port, read-first, block-RAM inferable.
- FSM, trigger comparator, timeout counter and wr_ptr live in the top.

## Test plan
- Reset mid-CAPTURE after 100 samples → busy=0, done=0 next cycle. Re-arm plus a ramp → a full, correct 256-sample frame.
- trig_level=0x80, auto_en=0, arm, ramp 0x70,0x78,0x80,… (one per strobe) → capture starts on 0x80; rd_addr 0 reads 0x80, rd_addr 1 reads 0x88; done after 256 strobes; auto_trig=0.
- Constant 0x90 > trig_level=0x80 after arm, auto_en=0 → no trigger (no rising crossing), busy stays 1 indefinitely.
- Constant 0x10, auto_en=1, TIMEOUT=1024 → capture forced on the 1024th strobe; auto_trig=1; all 256 frame words read 0x10.
- arm pulsed during CAPTURE → ignored, frame completes unchanged. arm in DONE → busy=1 next cycle, done=0.
- sample_valid coincident with arm, value crossing the level → not a trigger and not stored; the first crossing needs two further strobes.
